// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester memory arbiter (instruction fetch vs. data).
// Data normally wins a simultaneous request. A 3-bit starvation counter gives
// fetch the grant once data has won four times while fetch was waiting.
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   ifReq/ifAddr             fetch request (held until ifAck) and address
//   ifRdata/ifAck            fetched word, one-cycle completion pulse
//   dReq/dWe/dAddr/dWdata    data request (held until dAck), store flag, address, store data
//   dRdata/dAck              load data, one-cycle completion pulse
//   memReq/memWe/memAddr/memWdata  memory request side (registered)
//   memRdata/memAck          memory response (memAck ignored while memReq = 0)
//   ifStall/dStall           combinational freeze: req & ~ack
//   owner                    0 = fetch, 1 = data (last/current grant)
//   err                      timeout pulse (tied 0 unless timeout enabled)
// Optional feature: define ARB_TIMEOUT_EN to abort a grant after 255 cycles
// without memAck (ack pulses with rdata 24'hFFFFFF and err).
module mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifReq,
    input  logic [15:0] ifAddr,
    output logic [23:0] ifRdata,
    output logic        ifAck,
    input  logic        dReq,
    input  logic        dWe,
    input  logic [15:0] dAddr,
    input  logic [23:0] dWdata,
    output logic [23:0] dRdata,
    output logic        dAck,
    output logic        memReq,
    output logic        memWe,
    output logic [15:0] memAddr,
    output logic [23:0] memWdata,
    input  logic [23:0] memRdata,
    input  logic        memAck,
    output logic        ifStall,
    output logic        dStall,
    output logic        owner,
    output logic        err
);

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned DATA_W  = 24;
    localparam int unsigned STARV_W = 3;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_GRANT_IF = 2'd1;
    localparam logic [1:0] S_GRANT_D  = 2'd2;

    localparam logic [STARV_W-1:0] STARV_LIMIT = STARV_W'(4);
    localparam logic [DATA_W-1:0]  RDATA_ERR   = {DATA_W{1'b1}};

    logic [1:0]         state_q,     state_d;
    logic [STARV_W-1:0] starv_q,     starv_d;
    logic               mem_req_q,   mem_req_d;
    logic               mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic               if_ack_q,    if_ack_d;
    logic               d_ack_q,     d_ack_d;
    logic [DATA_W-1:0]  if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0]  d_rdata_q,   d_rdata_d;
    logic               owner_q,     owner_d;
    logic               if_pend, d_pend, starved;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned TMO_W = 8;
    // Counter starts at 0 on the first grant cycle, so 254 marks the 255th.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(254);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        starv_d     = starv_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        owner_d     = owner_q;
        if_pend     = ifReq & ~if_ack_q;
        d_pend      = dReq & ~d_ack_q;
        starved     = if_pend & d_pend & (starv_q == STARV_LIMIT);
`ifdef ARB_TIMEOUT_EN
        tmo_d       = '0;
        err_d       = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                // The cycle an ack is driven is a turnaround: the acked requester
                // is dropping its request, so arbitration waits one cycle and then
                // sees both requesters with data priority intact.
                if (!if_ack_q && !d_ack_q) begin
                    if (d_pend && !starved) begin
                        state_d     = S_GRANT_D;
                        mem_req_d   = 1'b1;
                        mem_we_d    = dWe;
                        mem_addr_d  = dAddr;
                        mem_wdata_d = dWdata;
                        owner_d     = 1'b1;
                        if (ifReq) begin
                            starv_d = starv_q + STARV_W'(1);
                        end
                    end else if (if_pend) begin
                        state_d    = S_GRANT_IF;
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = ifAddr;
                        owner_d    = 1'b0;
                        starv_d    = '0;
                    end
                end
            end
            S_GRANT_IF, S_GRANT_D: begin
                if (memAck) begin
                    state_d   = S_IDLE;
                    mem_req_d = 1'b0;
                    if (state_q == S_GRANT_IF) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = memRdata;
                    end else begin
                        d_ack_d = 1'b1;
                        if (!mem_we_q) begin
                            d_rdata_d = memRdata;
                        end
                    end
                end
`ifdef ARB_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    state_d   = S_IDLE;
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    if (state_q == S_GRANT_IF) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = RDATA_ERR;
                    end else begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = RDATA_ERR;
                    end
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
`endif
            end
            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset also abandons any access in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            starv_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            owner_q     <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            tmo_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            starv_q     <= starv_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            owner_q     <= owner_d;
`ifdef ARB_TIMEOUT_EN
            tmo_q       <= tmo_d;
            err_q       <= err_d;
`endif
        end
    end

    assign memReq   = mem_req_q;
    assign memWe    = mem_we_q;
    assign memAddr  = mem_addr_q;
    assign memWdata = mem_wdata_q;
    assign ifAck    = if_ack_q;
    assign dAck     = d_ack_q;
    assign ifRdata  = if_rdata_q;
    assign dRdata   = d_rdata_q;
    assign owner    = owner_q;
    assign ifStall  = ifReq & ~if_ack_q;
    assign dStall   = dReq & ~d_ack_q;

`ifdef ARB_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Clock and reset SHALL be one clock with synchronous, active-low reset: clk  input  1  rising-edge clock; rst  input  1  synchronous active-low reset (0 = reset, sampled on clk rising edge).
REQ-002 ifReq  input  1  fetch request, held high until ifAck; ifAddr  input  16  fetch address (PC).
REQ-003 ifRdata  output  24  fetched instruction word; ifAck  output  1  one-cycle completion pulse to fetch.
REQ-004 dReq  input  1  data request, held high until dAck; dWe  input  1  1 = store, 0 = load; dAddr  input  16  data address; dWdata  input  24  store data.
REQ-005 dRdata  output  24  load data; dAck  output  1  one-cycle completion pulse to data requester.
REQ-006 memReq  output  1  memory request; memWe  output  1  memory write enable; memAddr  output  16  memory address; memWdata  output  24  memory write data.
REQ-007 memRdata  input  24  memory read data, valid with memAck; memAck  input  1  memory completion, ignored while memReq = 0.
REQ-008 ifStall  output  1  ifReq & ~ifAck; dStall  output  1  dReq & ~dAck (combinational pipeline freeze); owner  output  1  0 = fetch, 1 = data (last/current grant); err  output  1  timeout pulse.

Function
REQ-009 FSM SHALL have states IDLE, GRANT_IF, GRANT_D.
REQ-010 IDLE: if dReq (and dAck = 0) -> GRANT_D; else if ifReq (and ifAck = 0) -> GRANT_IF; else stay. Data has priority except as REQ-011 specifies.
REQ-011 A 3-bit starvation counter SHALL increment on each GRANT_D entry while ifReq = 1, clear on GRANT_IF entry; at value 4, with both requests pending, IDLE SHALL go to GRANT_IF.
REQ-012 On grant entry, memAddr/memWe/memWdata SHALL be registered from the owner's inputs and held stable until exit; memWe = 0 for fetch grants.
REQ-013 memReq SHALL be 1 exactly in GRANT_IF/GRANT_D.
REQ-014 In GRANT_x with memAck = 1: memRdata SHALL be registered into xRdata, xAck = 1 in the next cycle only, FSM -> IDLE.
REQ-015 Minimum latency: request seen in IDLE at cycle N, memReq at N+1, memAck at N+1 -> xAck at N+2; next grant can issue at N+3.
REQ-016 A request SHALL be ignored in the cycle its own ack is high (requester drops req on ack); no duplicate access.
REQ-017 ifRdata/dRdata SHALL hold their last value until the next owner completion; stores leave dRdata unchanged.
REQ-018 Input changes on a requester's address/data while it is granted SHALL NOT affect the memory port.
REQ-019 Simultaneous ifReq and dReq in IDLE: one grant only, per REQ-010/011; the loser stays stalled.

Reset
REQ-020 rst = 0 SHALL force IDLE, memReq = 0, memWe = 0, memAddr = 0, memWdata = 0, ifAck = dAck = 0, ifRdata = dRdata = 0, owner = 0, err = 0, starvation/timeout counters = 0.
REQ-021 Reset mid-grant SHALL abandon the access; a memAck arriving during or the cycle after reset SHALL be ignored.

Configuration
REQ-022 Macro ARB_TIMEOUT_EN: when defined, an 8-bit counter SHALL run in GRANT_x; if 255 cycles elapse without memAck, FSM -> IDLE, memReq drops, owner's ack pulses with rdata = 24'hFFFFFF, and err pulses one cycle with the ack.
REQ-023 Without ARB_TIMEOUT_EN, GRANT_x SHALL wait indefinitely and err SHALL be tied 0.

Verification
REQ-024 Single fetch: ifReq = 1, ifAddr = 16'h0010, memAck at first memReq cycle with memRdata = 24'h1A2B3C -> ifAck one cycle later, ifRdata = 24'h1A2B3C, memWe = 0 throughout.
REQ-025 Conflict: ifReq and dReq (store, dAddr = 16'h0040, dWdata = 24'h00BEEF) rise same cycle -> data granted first with memWe = 1 and memWdata = 24'h00BEEF; fetch granted after dAck; ifStall high until ifAck.
REQ-026 Starvation: ifReq held, dReq reasserted immediately after each dAck -> after 4 data grants, fifth grant is fetch (owner = 0).
REQ-027 Reset mid-op: rst = 0 during GRANT_D with memAck = 1 on that cycle -> next cycle memReq = 0, dAck = 0, dRdata = 0, FSM IDLE.
REQ-028 Timeout (ARB_TIMEOUT_EN defined): load granted, memAck held 0 -> after 255 cycles dAck = 1, err = 1, dRdata = 24'hFFFFFF; without macro memReq stays 1 for 300+ cycles and err = 0.
